mc_ctrl_fsm: RTL
================

Name: mc_ctrl_fsm

Overview:
- Multi-cycle control unit for the 3-bit-opcode ISA. It replaces single-cycle combinational decoding with a sequenced FETCH/DECODE/EXEC/MEM/WB controller.
- Instruction width is parametrised.
- Instruction and data memories use a request/ready handshake, with an optional memory-wait watchdog.
- Sits between the instruction/data memory interfaces and the datapath (PC, register file, ALU). It owns the instruction register.

Parameters:
IW, 9, instruction width; opcode = ir[IW-1:IW-3], operand = ir[IW-4:0]; legal range IW >= 4.
HALT_OPERAND, 0, operand value that makes opcode 3'b111 a HALT rather than a JMP.
MEM_WAIT_MAX, 0, maximum cycles to wait for imem_ready/dmem_ready; 0 disables the watchdog.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  leave IDLE and begin fetching
instr_in  input  IW  instruction word from instruction memory
imem_ready  input  1  instruction memory data valid
dmem_ready  input  1  data memory access complete
zero  input  1  ALU zero flag, sampled in EXEC for BRZ
ir_out  output  IW  instruction register contents
imem_req  output  1  instruction fetch request
ir_load  output  1  IR capture strobe
pc_inc  output  1  PC <= PC+1 strobe
pc_load  output  1  PC <= branch target strobe
reg_write  output  1  register file write strobe
mem_read  output  1  data memory read request
mem_write  output  1  data memory write request
branch_zero  output  1  BRZ executing
branch_always  output  1  JMP executing
halt  output  1  core halted
err  output  1  watchdog timeout, sticky
state  output  3  current state encoding

Behaviour:
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Encoding 7 is illegal and recovers to IDLE on the next clock.
- Reset (async, any state, mid-transaction included):
  - state=IDLE, ir_out=0, err=0, watchdog counter=0.
  - All strobes 0 while reset is high and in the first cycle after reset deasserts.
- Outputs are combinational from the registered state, ir_out and input handshakes. No output is driven from a registered copy.
- IDLE: all strobes 0. start=1 -> FETCH next cycle.
- FETCH:
  - imem_req=1.
  - On imem_ready=1: ir_load=1 in the same cycle, ir_out <= instr_in at the clock edge, then -> DECODE.
  - Otherwise stay in FETCH.
- DECODE: all strobes 0. Next state from the opcode:
  - 000 ADD, 001 SUB, 010 AND, 011 LDI -> EXEC.
  - 100 LDR, 101 STR -> MEM.
  - 110 BRZ -> EXEC.
  - 111 with operand==HALT_OPERAND -> HALT; 111 otherwise (JMP) -> EXEC.
- EXEC (one cycle, then -> FETCH):
  - ALU/LDI: reg_write=1, pc_inc=1.
  - BRZ: branch_zero=1; pc_load=zero, pc_inc=~zero.
  - JMP: branch_always=1, pc_load=1.
- MEM:
  - LDR holds mem_read=1; STR holds mem_write=1, until dmem_ready=1.
  - On dmem_ready: LDR -> WB; STR asserts pc_inc=1 and -> FETCH.
- WB (one cycle, then -> FETCH): reg_write=1, pc_inc=1.
- HALT:
  - halt=1 held; all other strobes 0.
  - start is ignored. Exit only via reset.
- Strobe exclusivity: pc_inc and pc_load are never both 1. reg_write, mem_read and mem_write are one-hot or all zero.
- Retire latency, measured from the cycle entering FETCH with zero memory wait:
  - ALU/BRZ/JMP/STR: 3 cycles.
  - LDR: 4 cycles.
- Watchdog (MEM_WAIT_MAX>0):
  - Counter increments each cycle spent in FETCH with imem_ready=0, or in MEM with dmem_ready=0.
  - Counter clears on each state change.
  - When the counter reaches MEM_WAIT_MAX: -> HALT next cycle, err <= 1 (sticky until reset).
  - A ready that arrives in the same cycle the limit is reached wins; the transfer completes normally.
- With MEM_WAIT_MAX=0 the counter logic is absent and err is tied to 0.

Optional Feature:
- Macro: MC_CTRL_PERF_EN.
- Defined: adds output ports cycle_cnt[31:0] and retired_cnt[31:0].
  - cycle_cnt counts every cycle with state != IDLE and state != HALT.
  - retired_cnt increments on every transition into FETCH from EXEC, MEM or WB.
  - Both counters reset to 0 and wrap at 2^32.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset held 3 cycles in MEM with mem_read=1 -> state=0 and all strobes 0 immediately; ir_out=0.
- start, ADD 9'b000_000001, imem_ready=1 and dmem_ready=1 tied -> states 1,2,3,1; reg_write and pc_inc both 1 in the EXEC cycle only.
- LDR 9'b100_000010 with dmem_ready delayed 2 cycles -> mem_read high for exactly 3 MEM cycles; WB cycle shows reg_write=1 and pc_inc=1.
- BRZ with zero=1 -> pc_load=1, pc_inc=0; repeated with zero=0 -> pc_load=0, pc_inc=1; branch_zero=1 in both.
- Instruction 9'b111_000000 -> HALT; halt=1 stays high for 20 cycles with start pulsed; 9'b111_000101 -> branch_always=1, pc_load=1, back to FETCH.
- MEM_WAIT_MAX=4, imem_ready=0 forever -> HALT entered after 4 FETCH cycles with err=1; with MC_CTRL_PERF_EN, retired_cnt unchanged.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm -- multi-cycle control unit for the 3-bit-opcode ISA.
//
// Sequences each instruction through FETCH / DECODE / EXEC / MEM / WB and
// owns the instruction register. Every strobe is decoded combinationally
// from the registered state, the instruction register and the memory
// handshakes, so a strobe is seen in the same cycle as the condition that
// causes it.
//
// Parameters:
//   IW           instruction width (>= 4); opcode = ir[IW-1:IW-3], operand = ir[IW-4:0]
//   HALT_OPERAND operand value that turns opcode 3'b111 into HALT instead of JMP
//   MEM_WAIT_MAX memory-wait watchdog limit in cycles; 0 removes the watchdog
//
// Ports:
//   clk, reset             clock (rising edge), asynchronous active-high reset
//   start                  leave IDLE and begin fetching
//   instr_in, imem_ready   instruction memory data / data valid
//   dmem_ready             data memory access complete
//   zero                   ALU zero flag, used by BRZ in EXEC
//   ir_out                 instruction register
//   imem_req, ir_load      fetch request, IR capture strobe
//   pc_inc, pc_load        PC increment / branch-target load strobes
//   reg_write              register file write strobe
//   mem_read, mem_write    data memory requests
//   branch_zero            BRZ executing
//   branch_always          JMP executing
//   halt                   core halted
//   err                    watchdog timeout, sticky until reset
//   state                  current state encoding
//
// Optional build macro MC_CTRL_PERF_EN adds cycle_cnt[31:0] (cycles outside
// IDLE/HALT) and retired_cnt[31:0] (instructions retired).

module mc_ctrl_fsm #(
  parameter int IW           = 9,
  parameter int HALT_OPERAND = 0,
  parameter int MEM_WAIT_MAX = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [IW-1:0] instr_in,
  input  logic          imem_ready,
  input  logic          dmem_ready,
  input  logic          zero,
  output logic [IW-1:0] ir_out,
  output logic          imem_req,
  output logic          ir_load,
  output logic          pc_inc,
  output logic          pc_load,
  output logic          reg_write,
  output logic          mem_read,
  output logic          mem_write,
  output logic          branch_zero,
  output logic          branch_always,
  output logic          halt,
  output logic          err,
  output logic [2:0]    state
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0]   cycle_cnt,
  output logic [31:0]   retired_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [IW-4:0] HALT_OP = (IW-3)'(HALT_OPERAND);

  state_t        cur, nxt;
  logic [2:0]    opcode;
  logic [IW-4:0] operand;
  logic          wd_timeout;

  assign opcode  = ir_out[IW-1 -: 3];
  assign operand = ir_out[IW-4:0];
  assign state   = cur;

  // State register and instruction register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur    <= S_IDLE;
      ir_out <= '0;
    end else begin
      cur <= nxt;
      if (ir_load) ir_out <= instr_in;
    end
  end

  // Memory-wait watchdog. The limit check looks at the count before this
  // cycle's increment, so the MEM_WAIT_MAX-th consecutive wait cycle is the
  // one that redirects to HALT. A ready in that cycle clears 'waiting' and
  // therefore wins over the timeout.
  generate
    if (MEM_WAIT_MAX > 0) begin : g_wd
      localparam int CW = $clog2(MEM_WAIT_MAX + 1);
      logic [CW-1:0] wd_cnt;
      logic          err_q;
      logic          waiting;

      assign waiting    = ((cur == S_FETCH) && !imem_ready) ||
                          ((cur == S_MEM)   && !dmem_ready);
      assign wd_timeout = waiting && (wd_cnt == CW'(MEM_WAIT_MAX - 1));
      assign err        = err_q;

      // Any cycle that is not a continuing wait is either a state change or
      // a state where no wait is possible, so the count simply returns to 0.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          wd_cnt <= '0;
          err_q  <= 1'b0;
        end else begin
          if (waiting && !wd_timeout) wd_cnt <= wd_cnt + CW'(1);
          else                        wd_cnt <= '0;
          if (wd_timeout) err_q <= 1'b1;
        end
      end
    end else begin : g_no_wd
      assign wd_timeout = 1'b0;
      assign err        = 1'b0;
    end
  endgenerate

  // Next state and strobe decode
  always_comb begin
    nxt           = cur;
    imem_req      = 1'b0;
    ir_load       = 1'b0;
    pc_inc        = 1'b0;
    pc_load       = 1'b0;
    reg_write     = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    branch_zero   = 1'b0;
    branch_always = 1'b0;
    halt          = 1'b0;
    case (cur)
      S_IDLE: begin
        if (start) nxt = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_load = 1'b1;
          nxt     = S_DECODE;
        end else if (wd_timeout) begin
          nxt = S_HALT;
        end
      end
      S_DECODE: begin
        case (opcode)
          3'b100, 3'b101: nxt = S_MEM;
          3'b111:         nxt = (operand == HALT_OP) ? S_HALT : S_EXEC;
          default:        nxt = S_EXEC;
        endcase
      end
      S_EXEC: begin
        nxt = S_FETCH;
        case (opcode)
          3'b000, 3'b001, 3'b010, 3'b011: begin
            reg_write = 1'b1;
            pc_inc    = 1'b1;
          end
          3'b110: begin
            branch_zero = 1'b1;
            pc_load     = zero;
            pc_inc      = ~zero;
          end
          3'b111: begin
            branch_always = 1'b1;
            pc_load       = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        // Only LDR (100) and STR (101) reach MEM.
        if (opcode == 3'b101) mem_write = 1'b1;
        else                  mem_read  = 1'b1;
        if (dmem_ready) begin
          if (opcode == 3'b101) begin
            pc_inc = 1'b1;
            nxt    = S_FETCH;
          end else begin
            nxt = S_WB;
          end
        end else if (wd_timeout) begin
          nxt = S_HALT;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_inc    = 1'b1;
        nxt       = S_FETCH;
      end
      S_HALT: begin
        halt = 1'b1;
      end
      default: nxt = S_IDLE;
    endcase
  end

`ifdef MC_CTRL_PERF_EN
  // Performance counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt   <= '0;
      retired_cnt <= '0;
    end else begin
      if ((cur != S_IDLE) && (cur != S_HALT)) cycle_cnt <= cycle_cnt + 32'd1;
      if ((nxt == S_FETCH) && ((cur == S_EXEC) || (cur == S_MEM) || (cur == S_WB)))
        retired_cnt <= retired_cnt + 32'd1;
    end
  end
`endif

endmodule
